// File: rtl/imem_loader.sv
// Streams bytes into 32-bit little-endian words and writes them into instruction
// memory, holding the core in reset while a load session is in progress.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned START_ADDR = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] PC_write,
    output logic [31:0]           instruction_in,
    output logic                  imem_we,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            byte_cnt;
    logic [31:0]           word;
    logic                  last_q;
    logic [31:0]           assembled_c;

    // Current word with the incoming byte merged into its little-endian lane.
    always_comb begin
        assembled_c = word;
        case (byte_cnt)
            2'd0:    assembled_c[7:0]   = in_data;
            2'd1:    assembled_c[15:8]  = in_data;
            2'd2:    assembled_c[23:16] = in_data;
            default: assembled_c[31:24] = in_data;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            addr           <= '0;
            byte_cnt       <= 2'd0;
            word           <= 32'd0;
            last_q         <= 1'b0;
            in_ready       <= 1'b0;
            PC_write       <= '0;
            instruction_in <= 32'd0;
            imem_we        <= 1'b0;
            core_reset     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            words_written  <= '0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= COLLECT;
                        addr          <= ADDR_FIRST;
                        byte_cnt      <= 2'd0;
                        word          <= 32'd0;
                        last_q        <= 1'b0;
                        words_written <= '0;
                        err           <= 1'b0;
                        in_ready      <= 1'b1;
                        core_reset    <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (in_valid && in_ready) begin
                        word     <= assembled_c;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3 || in_last) begin
                            state          <= WRITE;
                            last_q         <= in_last;
                            in_ready       <= 1'b0;
                            imem_we        <= 1'b1;
                            PC_write       <= addr;
                            instruction_in <= assembled_c;
                            // A short final word is still written, but flagged.
                            if (byte_cnt != 2'd3) begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    byte_cnt      <= 2'd0;
                    word          <= 32'd0;
                    words_written <= words_written + CNT_WIDTH'(1);
                    if (addr != ADDR_MAX) begin
                        addr <= addr + ADDR_WIDTH'(1);
                    end
                    if (last_q || addr == ADDR_MAX) begin
                        // Running off the top of memory ends the session rather than wrapping.
                        if (!last_q) begin
                            err <= 1'b1;
                        end
                        state      <= DONE;
                        done       <= 1'b1;
                        core_reset <= 1'b0;
                    end else begin
                        state    <= COLLECT;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table-driven load sessions plus hand-written
// sequences for stalls, mid-session reset and ignored restart.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;

    logic        in_ready_a, imem_we_a, core_reset_a, busy_a, done_a, err_a;
    logic [9:0]  pc_a;
    logic [31:0] instr_a;
    logic [10:0] words_a;
    logic        in_ready_b, imem_we_b, core_reset_b, busy_b, done_b, err_b;
    logic [9:0]  pc_b;
    logic [31:0] instr_b;
    logic [10:0] words_b;

    imem_loader #(.ADDR_WIDTH(10), .START_ADDR(0)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready_a),
        .PC_write(pc_a), .instruction_in(instr_a), .imem_we(imem_we_a),
        .core_reset(core_reset_a), .busy(busy_a), .done(done_a), .err(err_a),
        .words_written(words_a)
    );

    imem_loader #(.ADDR_WIDTH(10), .START_ADDR(1022)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready_b),
        .PC_write(pc_b), .instruction_in(instr_b), .imem_we(imem_we_b),
        .core_reset(core_reset_b), .busy(busy_b), .done(done_b), .err(err_b),
        .words_written(words_b)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
        logic [31:0] cyc;
    } wr_t;

    typedef struct {
        bit          sel;
        int          n;
        logic [95:0] bytes;
        bit          last;
        int          acc;
        int          nw;
        logic [9:0]  a0;
        logic [31:0] d0;
        logic [9:0]  a1;
        logic [31:0] d1;
        bit          err;
        int          words;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;
    logic [31:0] cyc = 0;
    wr_t wq_a[$], wq_b[$];
    int  dn_a = 0, dn_b = 0, cv_a = 0, cv_b = 0;

    // Observe both loaders mid-cycle: log writes, done pulses and core_reset consistency.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (mon_en) begin
            if (imem_we_a) wq_a.push_back('{a: pc_a, d: instr_a, cyc: cyc});
            if (imem_we_b) wq_b.push_back('{a: pc_b, d: instr_b, cyc: cyc});
            if (done_a) dn_a++;
            if (done_b) dn_b++;
            if (core_reset_a !== (busy_a && !done_a)) cv_a++;
            if (core_reset_b !== (busy_b && !done_b)) cv_b++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wq_a.delete(); wq_b.delete();
        dn_a = 0; dn_b = 0; cv_a = 0; cv_b = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clock);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0; start_b = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input bit sel, input logic [7:0] d, input logic l, output bit ok);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!(sel ? in_ready_b : in_ready_a) && n < 20) begin
            @(negedge clock);
            n++;
        end
        ok = sel ? in_ready_b : in_ready_a;
        if (ok) @(negedge clock);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        for (int t = 0; t < 40 && (sel ? dn_b : dn_a) == 0; t++) @(negedge clock);
        repeat (3) @(negedge clock);
    endtask

    vec_t vecs[6];

    initial begin
        bit ok;
        int acc;
        wr_t w;

        vecs[0] = '{0, 4, 96'hFFFFFFFF, 1, 4, 1, 10'd0, 32'hFFFFFFFF, 10'd0, 32'h0, 0, 1};
        vecs[1] = '{0, 8, 96'h12345677_12345678, 1, 8, 2, 10'd0, 32'h12345678, 10'd1, 32'h12345677, 0, 2};
        vecs[2] = '{0, 2, 96'h2211, 1, 2, 1, 10'd0, 32'h00002211, 10'd0, 32'h0, 1, 1};
        vecs[3] = '{0, 5, 96'h05_04030201, 1, 5, 2, 10'd0, 32'h04030201, 10'd1, 32'h00000005, 1, 2};
        vecs[4] = '{1, 12, 96'h0B0A0908_07060504_03020100, 0, 8, 2, 10'd1022, 32'h03020100, 10'd1023, 32'h07060504, 1, 2};
        vecs[5] = '{0, 1, 96'h9A, 1, 1, 1, 10'd0, 32'h0000009A, 10'd0, 32'h0, 1, 1};

        do_reset();
        check("reset_outputs", {in_ready_a, imem_we_a, core_reset_a, busy_a, done_a, err_a, words_a, pc_a, instr_a}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            clear_mon();
            pulse_start(vecs[i].sel);
            acc = 0;
            for (int k = 0; k < vecs[i].n; k++) begin
                send_byte(vecs[i].sel, vecs[i].bytes[8*k +: 8], vecs[i].last && (k == vecs[i].n - 1), ok);
                if (!ok) break;
                acc++;
            end
            wait_done(vecs[i].sel);
            check($sformatf("v%0d_accepted", i), 64'(acc), 64'(vecs[i].acc));
            check($sformatf("v%0d_done_pulses", i), 64'(vecs[i].sel ? dn_b : dn_a), 64'd1);
            check($sformatf("v%0d_core_reset", i), 64'(vecs[i].sel ? cv_b : cv_a), 64'd0);
            check($sformatf("v%0d_err", i), 64'(vecs[i].sel ? err_b : err_a), 64'(vecs[i].err));
            check($sformatf("v%0d_words", i), 64'(vecs[i].sel ? words_b : words_a), 64'(vecs[i].words));
            check($sformatf("v%0d_num_writes", i), 64'(vecs[i].sel ? wq_b.size() : wq_a.size()), 64'(vecs[i].nw));
            for (int j = 0; j < vecs[i].nw && j < (vecs[i].sel ? wq_b.size() : wq_a.size()); j++) begin
                w = vecs[i].sel ? wq_b[j] : wq_a[j];
                check($sformatf("v%0d_write%0d", i, j), {22'd0, w.a, w.d},
                      {22'd0, (j == 0) ? vecs[i].a0 : vecs[i].a1, (j == 0) ? vecs[i].d0 : vecs[i].d1});
            end
            if (vecs[i].nw == 2 && (vecs[i].sel ? wq_b.size() : wq_a.size()) == 2) begin
                w = vecs[i].sel ? wq_b[0] : wq_a[0];
                acc = int'(vecs[i].sel ? wq_b[1].cyc : wq_a[1].cyc) - int'(w.cyc);
                check($sformatf("v%0d_write_spacing", i), 64'(acc), 64'(1 + vecs[i].acc - 4));
            end
        end

        // A fresh reset clears the sticky error and the held write bus.
        do_reset();
        check("reset_clears_err", {err_a, pc_a, instr_a, words_a}, 64'd0);

        // Stalled stream: gaps in in_valid must not lose bytes; write one cycle after the 4th byte.
        clear_mon();
        pulse_start(0);
        send_byte(0, 8'hAA, 1'b0, ok);
        send_byte(0, 8'hBB, 1'b0, ok);
        repeat (3) @(negedge clock);
        check("gap_ready_held", {in_ready_a, imem_we_a}, 64'b10);
        send_byte(0, 8'hCC, 1'b0, ok);
        send_byte(0, 8'hDD, 1'b1, ok);
        check("gap_write_latency", {imem_we_a, in_ready_a, instr_a}, {2'b10, 32'hDDCCBBAA});
        wait_done(0);
        check("gap_num_writes", 64'(wq_a.size()), 64'd1);
        check("gap_err", 64'(err_a), 64'd0);

        // Reset mid-word abandons it; a restart during COLLECT is ignored.
        do_reset();
        clear_mon();
        pulse_start(0);
        send_byte(0, 8'h01, 1'b0, ok);
        send_byte(0, 8'h02, 1'b0, ok);
        send_byte(0, 8'h03, 1'b0, ok);
        do_reset();
        check("midrst_no_write", 64'(wq_a.size()), 64'd0);
        check("midrst_idle", {busy_a, in_ready_a, core_reset_a}, 64'd0);
        pulse_start(0);
        send_byte(0, 8'h11, 1'b0, ok);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        send_byte(0, 8'h22, 1'b0, ok);
        send_byte(0, 8'h33, 1'b0, ok);
        send_byte(0, 8'h44, 1'b1, ok);
        wait_done(0);
        check("restart_num_writes", 64'(wq_a.size()), 64'd1);
        if (wq_a.size() > 0) check("restart_write", {22'd0, wq_a[0].a, wq_a[0].d}, {32'd0, 32'h44332211});
        check("restart_err_words", {err_a, words_a}, {1'b0, 11'd1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
